main_fsm: RTL and testbench
===========================

# main_fsm

Moore main state machine for the multicycle ARM control unit. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath's mux selects and the raw enable strobes that the conditional logic later gates. It sits inside `control_unit`, directly upstream of the datapath. Its decisions are based on `Op`/`Funct` fields taken from the instruction register.

## Interface
Parameters:
- none (state and select encodings come from the shared package)

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Op`  in  2  instruction bits [27:26], from the IR
- `Funct`  in  6  instruction bits [25:20]; bit 5 = I (immediate), bit 0 = L (load)
- `IRWrite`  out  1  IR load enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `ALUSrcA`  out  1  ALU A select: 0 = register A, 1 = PC
- `ALUSrcB`  out  2  ALU B select: 00 = register WriteData, 01 = ExtImm, 10 = constant 4
- `ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `NextPC`  out  1  unconditional PC update request
- `RegW`  out  1  raw register-write request (conditional logic gates it)
- `MemW`  out  1  raw memory-write request (conditional logic gates it)
- `Branch`  out  1  branch request (conditional logic gates it into PCWrite)
- `ALUOp`  out  1  1 = ALU decoder uses Funct; 0 = force ADD
- `State`  out  4  current state encoding, for debug and the bench

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.

Transitions:
- FETCH → DECODE.
- DECODE, chosen by `Op`:
  - `Op`=01 → MEMADR.
  - `Op`=00 and `Funct[5]`=0 → EXECUTER.
  - `Op`=00 and `Funct[5]`=1 → EXECUTEI.
  - `Op`=10 → BRANCH.
  - `Op`=11 (undefined) → FETCH, with no strobes issued.
- MEMADR: `Funct[0]`=1 → MEMREAD; otherwise → MEMWRITE.
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECUTER → ALUWB and EXECUTEI → ALUWB; ALUWB → FETCH.
- BRANCH → FETCH.

Per-state outputs. Any output not listed is 0; select fields not listed are 00.
- FETCH: `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, `IRWrite`=1, `NextPC`=1.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10. This produces PC+8 for R15 reads.
- MEMADR: `ALUSrcA`=0, `ALUSrcB`=01.
- MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
- MEMWB: `ResultSrc`=01, `RegW`=1.
- MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemW`=1.
- EXECUTER: `ALUSrcA`=0, `ALUSrcB`=00, `ALUOp`=1.
- EXECUTEI: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=1.
- ALUWB: `ResultSrc`=00, `RegW`=1. CMP/TST suppression is done by the downstream NoWrite logic, not here.
- BRANCH: `ALUSrcA`=0, `ALUSrcB`=01, `ResultSrc`=10, `Branch`=1.

Rules:
- Outputs are a pure function of `State`, except during reset (see below).
- `Op` and `Funct` are sampled only in DECODE and MEMADR. `IRWrite` is asserted only in FETCH, so both fields are stable there.
- The next-state logic has a default arm → FETCH. Illegal encodings recover in one cycle with all strobes 0.

## Timing
- Reset:
  - `Reset` high at a rising edge → `State`=FETCH on the next cycle.
  - While `Reset` is high, `IRWrite`, `NextPC`, `RegW`, `MemW` and `Branch` are forced to 0. Selects show the FETCH values.
  - Reset asserted mid-instruction aborts that instruction. No further strobes are issued.
  - First fetch strobe: the first cycle after `Reset` falls.
- Cycles per instruction, counted FETCH to the next FETCH:
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - undefined (`Op`=11): 2
- Strobe timing:
  - Every strobe is high for exactly one cycle per instruction.
  - `RegW`/`MemW`/`Branch` are never asserted in the same cycle as `IRWrite`.
  - At most one of `RegW`, `MemW`, `Branch` is high in any cycle.
- Latency: no combinational path from `Op`/`Funct` to any output. The only such path is to the next-state logic.

## Structure
- Package `arm_mc_pkg` holds:
  - the 4-bit state encodings, FETCH=0 through BRANCH=9;
  - the `ALUSrcB` constants SRCB_REG, SRCB_IMM, SRCB_FOUR;
  - the `ResultSrc` constants RES_ALUOUT, RES_DATA, RES_ALURESULT;
  - the `Op` constants OP_DP, OP_MEM, OP_BR.
- Single module: one state register plus two combinational blocks (next-state and output decode). No sub-module is needed.
- `control_unit` instantiates `main_fsm` beside its ALU decoder and conditional logic.

## Test plan
- Reset mid-MEMREAD, with `Reset` held 2 cycles: all strobes 0 during reset, then `State`=0. `IRWrite`=1 and `NextPC`=1 in the first post-reset cycle.
- ADD register (`Op`=00, `Funct`=000100): states 0,1,6,8,0. `ALUOp`=1 only in state 6. `RegW`=1 only in state 8. `ALUSrcB`=00 in state 6.
- ADD immediate (`Funct`=100100) then LDR (`Op`=01, `Funct`=011001):
  - ADD: states 0,1,7,8.
  - LDR: states 0,1,2,3,4,0, with `AdrSrc`=1 in state 3, `ResultSrc`=01 and `RegW`=1 in state 4.
- STR (`Op`=01, `Funct`=011000): states 0,1,2,5,0. `MemW`=1 only in state 5. `RegW` stays 0 throughout.
- B (`Op`=10): states 0,1,9,0. `Branch`=1, `ALUSrcB`=01, `ResultSrc`=10 in state 9.
- Undefined (`Op`=11): states 0,1,0. No `RegW`/`MemW`/`Branch`. A bench-forced illegal `State`=15 returns to 0 in one cycle.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: main FSM states,
// datapath select constants and instruction Op field values.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Moore main state machine of the multicycle ARM control unit: sequences each
// instruction and drives datapath selects plus the raw enable strobes.
module main_fsm
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State
);

    state_e state_q;
    state_e state_d;

    // Only I (bit 5) and L (bit 0) steer the sequence; the rest of Funct
    // belongs to the ALU decoder.
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the next-state default is assigned before the case so every path
    // drives state_d and no latch is inferred.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase

        // Reset is synchronous, so the register may still hold a mid-instruction
        // state here; present quiet FETCH selects until it takes effect.
        if (Reset) begin
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            ALUOp     = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: an instruction-level model queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_main_fsm;

    logic       clk;
    logic       Reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    main_fsm dut (
        .clk       (clk),
        .Reset     (Reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp,
    //                   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    typedef struct {
        logic [15:0] vec;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   active = 0;

    function automatic logic [15:0] observed();
        return {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp,
                AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    // Datapath selects each step presents: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    function automatic logic [5:0] selects(input int st);
        case (st)
            0, 1: return {1'b0, 1'b1, 2'b10, 2'b10};
            2:    return {1'b0, 1'b0, 2'b01, 2'b00};
            3:    return {1'b1, 1'b0, 2'b00, 2'b00};
            4:    return {1'b0, 1'b0, 2'b00, 2'b01};
            5:    return {1'b1, 1'b0, 2'b00, 2'b00};
            7:    return {1'b0, 1'b0, 2'b01, 2'b00};
            9:    return {1'b0, 1'b0, 2'b01, 2'b10};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [15:0] reset_vec(input int st);
        return {st[3:0], 6'b000000, selects(0)};
    endfunction

    task automatic cycle(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                         input logic [15:0] vec, input int id);
        exp_t e;
        Reset = rst;
        Op    = op;
        Funct = fn;
        e.vec = vec;
        e.id  = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH up to the next FETCH; abort_at >= 0 raises
    // Reset for two cycles starting at that step and drops the remainder.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input int abort_at, input int id);
        int steps[$];
        int len;
        bit is_load;
        logic [1:0]  drv_op;
        logic [5:0]  drv_fn;
        logic [15:0] v;
        logic        first, last;
        steps = '{0, 1};
        is_load = fn[0];
        case (op)
            2'b00: begin steps.push_back(fn[5] ? 7 : 6); steps.push_back(8); end
            2'b01: begin
                steps.push_back(2);
                if (is_load) begin steps.push_back(3); steps.push_back(4); end
                else steps.push_back(5);
            end
            2'b10: steps.push_back(9);
            default: ;
        endcase
        len = steps.size();
        for (int pos = 0; pos < len; pos++) begin
            // Op/Funct only matter in DECODE and MEMADR; elsewhere drive noise.
            if (pos == 1 || pos == 2) begin
                drv_op = op;
                drv_fn = fn;
            end else begin
                drv_op = 2'($urandom_range(0, 3));
                drv_fn = 6'($urandom_range(0, 63));
            end
            if (pos == abort_at) begin
                cycle(1'b1, drv_op, drv_fn, reset_vec(steps[pos]), id);
                cycle(1'b1, drv_op, drv_fn, reset_vec(0), id);
                return;
            end
            first = (pos == 0);
            last  = (pos == len - 1) && (len > 2);
            v = {steps[pos][3:0],
                 first, first,
                 last && (op == 2'b00 || (op == 2'b01 && is_load)),
                 last && (op == 2'b01 && !is_load),
                 last && (op == 2'b10),
                 (op == 2'b00 && pos == 2),
                 selects(steps[pos])};
            cycle(1'b0, drv_op, drv_fn, v, id);
        end
    endtask

    // Monitor: compares whatever the model expects for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("cycle_instr%0d", e.id), observed(), e.vec);
            end else if (active) begin
                check("scoreboard_underflow", 16'hFFFF, 16'h0000);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int ab;
        logic [1:0] op;
        logic [5:0] fn;
        Reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'd0;
        @(posedge clk);
        #1;
        active = 1;
        cycle(1'b1, 2'b00, 6'd0, reset_vec(0), 0);

        run_instr(2'b00, 6'b000100, -1, 1);   // ADD register
        run_instr(2'b00, 6'b100100, -1, 2);   // ADD immediate
        run_instr(2'b01, 6'b011001, -1, 3);   // LDR
        run_instr(2'b01, 6'b011000, -1, 4);   // STR
        run_instr(2'b10, 6'($urandom_range(0, 63)), -1, 5);  // B
        run_instr(2'b11, 6'($urandom_range(0, 63)), -1, 6);  // undefined
        run_instr(2'b01, 6'b011001, 3, 7);    // LDR aborted in MEMREAD
        run_instr(2'b00, 6'b000100, -1, 8);

        id = 100;
        repeat (300) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom_range(0, 63));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, ab, id);
            id++;
        end
        active = 0;

        // Illegal encoding: park in DECODE of an undefined op, force 15.
        Reset = 1'b0;
        Op    = 2'b11;
        Funct = 6'd0;
        @(posedge clk);
        #1;
        check("decode_before_force", observed(), {4'd1, 6'b000000, selects(1)});
        force dut.state_q = arm_mc_pkg::state_e'(4'hF);
        #1;
        check("illegal_state_quiet", observed(), {4'hF, 12'h000});
        release dut.state_q;
        @(posedge clk);
        #1;
        check("illegal_state_recover", observed(), {4'd0, 6'b110000, selects(0)});

        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
